// File: rtl/arc_engine.sv
// Octant-masked midpoint circle plotter with optional full-screen clear, one pixel slot per cycle.
// VGA outputs are registered from next-state values so the first pixel appears the cycle after start.
module arc_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                clear_first,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [X_W-1:0]      radius,
  input  logic [7:0]          octant_mask,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int CW = X_W + 3;
  localparam int PW = ((X_W > Y_W) ? X_W : Y_W) + 3;

  localparam logic signed [CW-1:0] ONE    = CW'(1);
  localparam logic [X_W-1:0]       X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]       Y_LAST = Y_W'(SCREEN_H - 1);
  localparam logic signed [PW-1:0] X_LIM  = PW'(SCREEN_W);
  localparam logic signed [PW-1:0] Y_LIM  = PW'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

  state_t                state, n_state;
  logic [2:0]            slot, n_slot;
  logic signed [CW-1:0]  ox, oy, crit, n_ox, n_oy, n_crit;
  logic [X_W-1:0]        clr_x, n_clr_x;
  logic [Y_W-1:0]        clr_y, n_clr_y;
  logic [COLOUR_W-1:0]   lat_colour, n_colour;
  logic [X_W-1:0]        lat_cx, n_cx, lat_r, n_r;
  logic [Y_W-1:0]        lat_cy, n_cy;
  logic [7:0]            lat_mask, n_mask;

  logic signed [PW-1:0]  cx_e, cy_e, ox_e, oy_e, px, py;
  logic [X_W-1:0]        o_x;
  logic [Y_W-1:0]        o_y;
  logic [COLOUR_W-1:0]   o_c;
  logic                  o_p;

  always_comb begin
    n_state  = state;
    n_slot   = slot;
    n_ox     = ox;
    n_oy     = oy;
    n_crit   = crit;
    n_clr_x  = clr_x;
    n_clr_y  = clr_y;
    n_colour = lat_colour;
    n_cx     = lat_cx;
    n_cy     = lat_cy;
    n_r      = lat_r;
    n_mask   = lat_mask;

    case (state)
      IDLE: begin
        if (start) begin
          n_colour = colour;
          n_cx     = centre_x;
          n_cy     = centre_y;
          n_r      = radius;
          n_mask   = octant_mask;
          n_clr_x  = '0;
          n_clr_y  = '0;
          n_slot   = '0;
          n_ox     = $signed(CW'(radius));
          n_oy     = '0;
          n_crit   = ONE - $signed(CW'(radius));
          n_state  = clear_first ? CLEAR : DRAW;
        end
      end
      CLEAR: begin
        if (clr_x == X_LAST) begin
          n_clr_x = '0;
          if (clr_y == Y_LAST) begin
            n_clr_y = '0;
            n_state = DRAW;
          end else begin
            n_clr_y = clr_y + 1'b1;
          end
        end else begin
          n_clr_x = clr_x + 1'b1;
        end
      end
      DRAW: begin
        if (slot == 3'd7) begin
          n_slot = '0;
          n_oy   = oy + ONE;
          // Midpoint decision uses the already-stepped oy/ox.
          if (crit[CW-1] || crit == '0) begin
            n_crit = crit + n_oy + n_oy + ONE;
          end else begin
            n_ox   = ox - ONE;
            n_crit = crit + (n_oy - n_ox) + (n_oy - n_ox) + ONE;
          end
          if (n_oy > n_ox) n_state = DONE;
        end else begin
          n_slot = slot + 3'd1;
        end
      end
      DONE: begin
        if (!start) n_state = IDLE;
      end
      default: n_state = IDLE;
    endcase
  end

  always_comb begin
    cx_e = $signed(PW'(n_cx));
    cy_e = $signed(PW'(n_cy));
    ox_e = PW'(n_ox);
    oy_e = PW'(n_oy);
    px   = cx_e + ox_e;
    py   = cy_e + oy_e;
    case (n_slot)
      3'd0: begin px = cx_e + ox_e; py = cy_e + oy_e; end
      3'd1: begin px = cx_e + oy_e; py = cy_e + ox_e; end
      3'd2: begin px = cx_e - oy_e; py = cy_e + ox_e; end
      3'd3: begin px = cx_e - ox_e; py = cy_e + oy_e; end
      3'd4: begin px = cx_e - ox_e; py = cy_e - oy_e; end
      3'd5: begin px = cx_e - oy_e; py = cy_e - ox_e; end
      3'd6: begin px = cx_e + oy_e; py = cy_e - ox_e; end
      default: begin px = cx_e + ox_e; py = cy_e - oy_e; end
    endcase

    o_x = '0;
    o_y = '0;
    o_c = '0;
    o_p = 1'b0;
    if (n_state == CLEAR) begin
      o_x = n_clr_x;
      o_y = n_clr_y;
      o_p = 1'b1;
    end else if (n_state == DRAW) begin
      o_x = px[X_W-1:0];
      o_y = py[Y_W-1:0];
      o_c = n_colour;
      // Off-screen points are dropped rather than wrapped.
      o_p = n_mask[n_slot] && !px[PW-1] && (px < X_LIM) && !py[PW-1] && (py < Y_LIM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      slot       <= '0;
      ox         <= '0;
      oy         <= '0;
      crit       <= '0;
      clr_x      <= '0;
      clr_y      <= '0;
      lat_colour <= '0;
      lat_cx     <= '0;
      lat_cy     <= '0;
      lat_r      <= '0;
      lat_mask   <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      state      <= n_state;
      slot       <= n_slot;
      ox         <= n_ox;
      oy         <= n_oy;
      crit       <= n_crit;
      clr_x      <= n_clr_x;
      clr_y      <= n_clr_y;
      lat_colour <= n_colour;
      lat_cx     <= n_cx;
      lat_cy     <= n_cy;
      lat_r      <= n_r;
      lat_mask   <= n_mask;
      vga_x      <= o_x;
      vga_y      <= o_y;
      vga_colour <= o_c;
      vga_plot   <= o_p;
    end
  end

  assign busy = (state == CLEAR) || (state == DRAW);
  assign done = (state == DONE);

endmodule

// File: tb/tb_arc_engine.sv
// Directed and random arcs compared cycle-by-cycle against a queue of expected pixels.
module tb_arc_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       clear_first = 1'b0;
  logic [2:0] colour = '0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] radius = '0;
  logic [7:0] octant_mask = '0;
  logic       busy, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  arc_engine dut (
    .clk(clk), .rst(rst), .start(start), .clear_first(clear_first),
    .colour(colour), .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .octant_mask(octant_mask), .busy(busy), .done(done), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct {bit plot; int x; int y; int c;} pix_t;
  pix_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pack_out();
    return {11'b0, busy, done, vga_plot,
            vga_plot ? vga_x : 8'd0, vga_plot ? vga_y : 7'd0, vga_plot ? vga_colour : 3'd0};
  endfunction

  function automatic logic [31:0] pack_exp(input bit b, input bit d, input pix_t p);
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    ex = p.plot ? 8'(p.x) : 8'd0;
    ey = p.plot ? 7'(p.y) : 7'd0;
    ec = p.plot ? 3'(p.c) : 3'd0;
    return {11'b0, b, d, p.plot, ex, ey, ec};
  endfunction

  // Reference: whole-frame clear (if asked) then the midpoint circle, eight slots per step.
  task automatic build(input int cx, input int cy, input int r, input logic [7:0] m,
                       input bit clr, input int col);
    int ox, oy, crit, x, y;
    pix_t p;
    exp_q.delete();
    if (clr)
      for (int yy = 0; yy < 120; yy++)
        for (int xx = 0; xx < 160; xx++) begin
          p = '{1'b1, xx, yy, 0};
          exp_q.push_back(p);
        end
    ox = r; oy = 0; crit = 1 - r;
    do begin
      for (int k = 0; k < 8; k++) begin
        case (k)
          0: begin x = cx + ox; y = cy + oy; end
          1: begin x = cx + oy; y = cy + ox; end
          2: begin x = cx - oy; y = cy + ox; end
          3: begin x = cx - ox; y = cy + oy; end
          4: begin x = cx - ox; y = cy - oy; end
          5: begin x = cx - oy; y = cy - ox; end
          6: begin x = cx + oy; y = cy - ox; end
          default: begin x = cx + ox; y = cy - oy; end
        endcase
        p = '{m[k] && x >= 0 && x < 160 && y >= 0 && y < 120, x, y, col};
        exp_q.push_back(p);
      end
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
  endtask

  task automatic launch(input int cx, input int cy, input int r, input logic [7:0] m,
                        input bit clr, input int col);
    @(negedge clk);
    centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r);
    octant_mask = m; clear_first = clr; colour = 3'(col); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic scramble();
    centre_x = 8'($urandom); centre_y = 7'($urandom); radius = 8'($urandom);
    octant_mask = 8'($urandom); clear_first = 1'($urandom); colour = 3'($urandom);
  endtask

  task automatic run_arc(input string tag, input int cx, input int cy, input int r,
                         input logic [7:0] m, input bit clr, input int col);
    pix_t idle_p;
    idle_p = '{1'b0, 0, 0, 0};
    build(cx, cy, r, m, clr, col);
    launch(cx, cy, r, m, clr, col);
    foreach (exp_q[i]) begin
      check($sformatf("%s px%0d", tag, i), pack_out(), pack_exp(1'b1, 1'b0, exp_q[i]));
      scramble();
      @(negedge clk);
    end
    check({tag, " done"}, pack_out(), pack_exp(1'b0, 1'b1, idle_p));
    @(negedge clk);
    check({tag, " idle"}, pack_out(), pack_exp(1'b0, 1'b0, idle_p));
  endtask

  initial begin
    pix_t idle_p;
    int   cx, cy, r;
    idle_p = '{1'b0, 0, 0, 0};

    #2;
    check("reset outputs", {11'b0, busy, done, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", pack_out(), pack_exp(1'b0, 1'b0, idle_p));

    run_arc("r0", 10, 10, 0, 8'hFF, 1'b0, 5);
    run_arc("r1", 50, 50, 1, 8'hFF, 1'b0, 2);
    run_arc("corner", 0, 0, 5, 8'hFF, 1'b0, 7);
    run_arc("oct0", 80, 60, 3, 8'h01, 1'b0, 3);
    run_arc("edge", 159, 119, 20, 8'hFF, 1'b0, 6);
    run_arc("clear", 80, 60, 10, 8'hA5, 1'b1, 4);

    // Reset pulse partway through an arc, then a fresh start.
    build(70, 40, 12, 8'hFF, 1'b0, 1);
    launch(70, 40, 12, 8'hFF, 1'b0, 1);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("pre-rst px%0d", i), pack_out(), pack_exp(1'b1, 1'b0, exp_q[i]));
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("mid-draw reset", {11'b0, busy, done, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle after mid reset", pack_out(), pack_exp(1'b0, 1'b0, idle_p));
    run_arc("redraw", 70, 40, 12, 8'hFF, 1'b0, 1);

    for (int t = 0; t < 6; t++) begin
      cx = $urandom_range(0, 159);
      cy = $urandom_range(0, 119);
      r  = $urandom_range(0, 60);
      run_arc($sformatf("rand%0d", t), cx, cy, r, 8'($urandom), 1'b0, $urandom_range(0, 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
